// File: rtl/nor3_selftest_ctrl.sv
// Built-in self-test sequencer for a 3-input NOR gate.
// It walks all eight input vectors in order 000..111 as {a,b,c}.
// Each vector is held for a settle interval, then the gate output is sampled once.
// Mismatching vectors are recorded in fail_vec and counted in err_cnt.
module nor3_selftest_ctrl #(
   parameter int SETTLE_CYC = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   output logic       din_a,
   output logic       din_b,
   output logic       din_c,
   input  logic       gate_dout,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] err_cnt,
   output logic [7:0] fail_vec
);

   // A settle interval below one cycle is treated as one cycle.
   localparam int unsigned SETTLE_EFF = (SETTLE_CYC < 1) ? 32'd1 : 32'(SETTLE_CYC);
   localparam int unsigned CNT_W      = $clog2(SETTLE_EFF + 1);
   localparam int unsigned VEC_W      = 3;
   localparam int unsigned ERR_W      = 4;
   localparam int unsigned NVEC       = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_SAMPLE,
      S_DONE
   } state_t;

   state_t             state_q;
   logic [VEC_W-1:0]   vec_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [VEC_W-1:0]   din_q;
   logic               busy_q;
   logic               done_q;
   logic               pass_q;
   logic [ERR_W-1:0]   err_cnt_q;
   logic [NVEC-1:0]    fail_vec_q;

   logic [CNT_W-1:0]   cnt_d;
   logic               expected_c;
   logic               mismatch_c;
   logic [ERR_W-1:0]   err_cnt_d;
   logic [NVEC-1:0]    fail_vec_d;

   // Settle count and the result of comparing the gate against the NOR of the current vector.
   always_comb begin
      cnt_d      = cnt_q + CNT_W'(1);
      expected_c = (vec_q == VEC_W'(0));
      mismatch_c = (gate_dout != expected_c);
      err_cnt_d  = err_cnt_q;
      fail_vec_d = fail_vec_q;
      if (mismatch_c) begin
         err_cnt_d  = err_cnt_q + ERR_W'(1);
         fail_vec_d = fail_vec_q | (NVEC'(1) << vec_q);
      end
   end

   // Sequencer state and registered outputs. Reset is synchronous and overrides everything.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         vec_q      <= '0;
         cnt_q      <= '0;
         din_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         err_cnt_q  <= '0;
         fail_vec_q <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  state_q    <= S_DRIVE;
                  vec_q      <= '0;
                  cnt_q      <= '0;
                  din_q      <= '0;
                  busy_q     <= 1'b1;
                  pass_q     <= 1'b0;
                  err_cnt_q  <= '0;
                  fail_vec_q <= '0;
               end
            end
            S_DRIVE: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  din_q   <= '0;
                  busy_q  <= 1'b0;
                  pass_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_d;
                  if (cnt_d == CNT_W'(SETTLE_EFF)) begin
                     state_q <= S_SAMPLE;
                  end
               end
            end
            S_SAMPLE: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  din_q   <= '0;
                  busy_q  <= 1'b0;
                  pass_q  <= 1'b0;
               end else begin
                  err_cnt_q  <= err_cnt_d;
                  fail_vec_q <= fail_vec_d;
                  cnt_q      <= '0;
                  if (vec_q == VEC_W'(NVEC - 1)) begin
                     state_q <= S_DONE;
                     din_q   <= '0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (err_cnt_d == ERR_W'(0));
                  end else begin
                     state_q <= S_DRIVE;
                     vec_q   <= vec_q + VEC_W'(1);
                     din_q   <= vec_q + VEC_W'(1);
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               if (abort) begin
                  pass_q <= 1'b0;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign din_a    = din_q[2];
   assign din_b    = din_q[1];
   assign din_c    = din_q[0];
   assign busy     = busy_q;
   assign done     = done_q;
   assign pass     = pass_q;
   assign err_cnt  = err_cnt_q;
   assign fail_vec = fail_vec_q;

endmodule

// File: tb/tb_nor3_selftest_ctrl.sv
// Self-checking bench for nor3_selftest_ctrl: one instance with a 1-cycle settle and one with a 3-cycle settle.
// A behavioural gate model can be healthy, stuck at 0, stuck at 1, or replaced by an OR gate.
module tb_nor3_selftest_ctrl;

   logic clk;
   logic rst_n;
   logic start_r;
   logic abort_r;
   logic sel;
   logic [1:0] mode;

   logic a1, b1, c1, g1, busy1, done1, pass1;
   logic [3:0] err1;
   logic [7:0] fail1;
   logic a3, b3, c3, g3, busy3, done3, pass3;
   logic [3:0] err3;
   logic [7:0] fail3;

   logic start1, start3, abort1, abort3;
   logic [2:0] o_din;
   logic o_busy, o_done, o_pass;
   logic [3:0] o_err;
   logic [7:0] o_fail;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] err;
      logic [7:0] fail;
      logic       pass;
      int         lat;
   } exp_t;
   exp_t sb_q[$];

   typedef struct {
      bit         use3;
      logic [1:0] mode;
      bit         poke;
      logic [3:0] err;
      logic [7:0] fail;
      logic       pass;
   } vec_t;
   vec_t tbl[6];

   // Gate models: 0 healthy NOR, 1 stuck at 0, 2 stuck at 1, 3 OR gate.
   function automatic logic gate_fn(input logic [1:0] m, input logic [2:0] v);
      case (m)
         2'd0:    return ~|v;
         2'd1:    return 1'b0;
         2'd2:    return 1'b1;
         default: return |v;
      endcase
   endfunction

   assign start1 = start_r && !sel;
   assign start3 = start_r && sel;
   assign abort1 = abort_r && !sel;
   assign abort3 = abort_r && sel;
   assign g1 = gate_fn(mode, {a1, b1, c1});
   assign g3 = gate_fn(mode, {a3, b3, c3});

   assign o_din  = sel ? {a3, b3, c3} : {a1, b1, c1};
   assign o_busy = sel ? busy3 : busy1;
   assign o_done = sel ? done3 : done1;
   assign o_pass = sel ? pass3 : pass1;
   assign o_err  = sel ? err3  : err1;
   assign o_fail = sel ? fail3 : fail1;

   nor3_selftest_ctrl #(.SETTLE_CYC(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
      .din_a(a1), .din_b(b1), .din_c(c1), .gate_dout(g1),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_vec(fail1)
   );

   nor3_selftest_ctrl #(.SETTLE_CYC(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
      .din_a(a3), .din_b(b3), .din_c(c3), .gate_dout(g3),
      .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .fail_vec(fail3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_din"},  32'(o_din),  32'd0);
      check({tag, "_busy"}, 32'(o_busy), 32'd0);
      check({tag, "_done"}, 32'(o_done), 32'd0);
      check({tag, "_pass"}, 32'(o_pass), 32'd0);
      check({tag, "_err"},  32'(o_err),  32'd0);
      check({tag, "_fail"}, 32'(o_fail), 32'd0);
   endtask

   // One complete run: expected results are queued at start and popped when done appears.
   task automatic run_vec(input vec_t r);
      exp_t e;
      exp_t got;
      int   s;
      bit   seen;
      sel  = r.use3;
      mode = r.mode;
      s    = r.use3 ? 3 : 1;
      e.err  = r.err;
      e.fail = r.fail;
      e.pass = r.pass;
      e.lat  = 1 + 8 * (s + 1);
      sb_q.push_back(e);
      seen = 1'b0;
      @(negedge clk);
      start_r = 1'b1;
      for (int j = 1; j <= 100; j++) begin
         @(negedge clk);
         if (o_done) begin
            if (sb_q.size() == 0) begin
               check("sb_empty", 32'd1, 32'd0);
            end else begin
               got = sb_q.pop_front();
               check("done_latency", 32'(j), 32'(got.lat));
               check("run_err",  32'(o_err),  32'(got.err));
               check("run_fail", 32'(o_fail), 32'(got.fail));
               check("run_pass", 32'(o_pass), 32'(got.pass));
               check("done_busy", 32'(o_busy), 32'd0);
               check("done_din",  32'(o_din),  32'd0);
            end
            seen = 1'b1;
            break;
         end else if (j <= 8 * (s + 1)) begin
            check("run_busy", 32'(o_busy), 32'd1);
            check("run_din",  32'(o_din),  32'((j - 1) / (s + 1)));
         end
         if (j == 1) start_r = 1'b0;
         if (r.poke && j == 5) start_r = 1'b1;
         if (r.poke && j == 6) start_r = 1'b0;
      end
      start_r = 1'b0;
      if (!seen) check("done_timeout", 32'd0, 32'd1);
      @(negedge clk);
      check("done_width", 32'(o_done), 32'd0);
      check("idle_pass_hold", 32'(o_pass), 32'(r.pass));
   endtask

   task automatic count_done(input int n, input string name);
      int hits;
      hits = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (o_done) hits++;
      end
      check(name, 32'(hits), 32'd0);
   endtask

   initial begin
      tbl[0] = '{use3: 1'b0, mode: 2'd0, poke: 1'b0, err: 4'd0, fail: 8'h00, pass: 1'b1};
      tbl[1] = '{use3: 1'b0, mode: 2'd1, poke: 1'b0, err: 4'd1, fail: 8'h01, pass: 1'b0};
      tbl[2] = '{use3: 1'b0, mode: 2'd2, poke: 1'b1, err: 4'd7, fail: 8'hFE, pass: 1'b0};
      tbl[3] = '{use3: 1'b0, mode: 2'd3, poke: 1'b0, err: 4'd8, fail: 8'hFF, pass: 1'b0};
      tbl[4] = '{use3: 1'b1, mode: 2'd0, poke: 1'b0, err: 4'd0, fail: 8'h00, pass: 1'b1};
      tbl[5] = '{use3: 1'b1, mode: 2'd2, poke: 1'b1, err: 4'd7, fail: 8'hFE, pass: 1'b0};

      rst_n   = 1'b0;
      start_r = 1'b0;
      abort_r = 1'b0;
      sel     = 1'b0;
      mode    = 2'd0;
      repeat (3) @(negedge clk);
      sel = 1'b0;
      #1 check_all_zero("rst1");
      sel = 1'b1;
      #1 check_all_zero("rst3");
      sel = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) run_vec(tbl[i]);

      // Abort while vector 3 is being driven, with a stuck-at-1 gate so partial results are non-zero.
      sel  = 1'b0;
      mode = 2'd2;
      @(negedge clk);
      start_r = 1'b1;
      for (int j = 1; j <= 7; j++) begin
         @(negedge clk);
         if (j == 1) start_r = 1'b0;
      end
      check("abort_pre_din",  32'(o_din),  32'd3);
      check("abort_pre_busy", 32'(o_busy), 32'd1);
      abort_r = 1'b1;
      @(negedge clk);
      abort_r = 1'b0;
      check("abort_busy", 32'(o_busy), 32'd0);
      check("abort_din",  32'(o_din),  32'd0);
      check("abort_err",  32'(o_err),  32'd2);
      check("abort_fail", 32'(o_fail), 32'h06);
      check("abort_pass", 32'(o_pass), 32'd0);
      check("abort_done", 32'(o_done), 32'd0);
      count_done(20, "abort_no_done");
      check("abort_err_hold", 32'(o_err), 32'd2);
      run_vec(tbl[0]);

      // Reset in the middle of a failing run.
      mode = 2'd2;
      @(negedge clk);
      start_r = 1'b1;
      for (int j = 1; j <= 9; j++) begin
         @(negedge clk);
         if (j == 1) start_r = 1'b0;
      end
      check("prerst_err", 32'(o_err), 32'd3);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_all_zero("midrst");
      count_done(20, "midrst_no_done");

      // Start and abort together in idle: abort wins.
      mode = 2'd0;
      start_r = 1'b1;
      abort_r = 1'b1;
      @(negedge clk);
      start_r = 1'b0;
      abort_r = 1'b0;
      check("sa_busy", 32'(o_busy), 32'd0);
      repeat (3) @(negedge clk);
      check("sa_busy_later", 32'(o_busy), 32'd0);
      check("sa_din", 32'(o_din), 32'd0);

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/nor3_selftest_ctrl.md
Name: nor3_selftest_ctrl

Overview:
Sequencing controller for the 3-input NOR gate (nor_gate: din_a, din_b, din_c -> dout).
- On start, drives all 8 input combinations into the gate in truth-table order, waits a settle interval, samples dout and compares it with the expected NOR value.
- Reports per-vector failures, an error count and a pass flag.
- Sits beside the gate as its built-in self-test sequencer.

Parameters:
SETTLE_CYC, 1, cycles each vector is held before sampling; values below 1 behave as 1.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous active-low reset.
start  input  1  begin a test run; sampled only in IDLE.
abort  input  1  synchronous abort; priority over start.
din_a  output  1  gate input a, registered; equals vec[2].
din_b  output  1  gate input b, registered; equals vec[1].
din_c  output  1  gate input c, registered; equals vec[0].
gate_dout  input  1  output of the NOR gate under test.
busy  output  1  high in DRIVE and SAMPLE.
done  output  1  one-cycle pulse at end of a completed run.
pass  output  1  high when the last completed run had zero errors; held.
err_cnt  output  4  number of mismatching vectors in current/last run (0..8).
fail_vec  output  8  bit i set when vector i mismatched.

Behaviour:
- Reset, synchronous (rst_n low at a clk edge):
  - State goes to IDLE; vec=0, settle counter=0.
  - din_a/b/c=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0.
  - Reset overrides abort and start, in any state including mid-run.
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE, start=1 and abort=0:
  - Clear err_cnt, fail_vec and pass.
  - vec=0, go to DRIVE; din outputs become 000 on the following cycle.
- DRIVE:
  - Hold din = vec; settle counter counts 1..SETTLE_CYC.
  - At the SETTLE_CYC-th cycle, go to SAMPLE.
- SAMPLE (one cycle):
  - expected = ~(vec[2]|vec[1]|vec[0]), i.e. 1 only for vec=0.
  - If gate_dout != expected: set fail_vec[vec] and increment err_cnt.
  - If vec=7, go to DONE; else vec=vec+1, reset settle counter, go to DRIVE.
- DONE (one cycle):
  - done=1, pass=(err_cnt==0), din=000, busy=0, then go to IDLE.
- Latency: start seen at edge t gives DRIVE from t+1; each vector takes SETTLE_CYC+1 cycles; done is high in cycle t+1+8*(SETTLE_CYC+1). With SETTLE_CYC=1, done is at t+17.
- Vector order is 000,001,010,011,100,101,110,111 as {a,b,c}.
- start while busy or in DONE is ignored.
- abort=1 in DRIVE/SAMPLE/DONE:
  - Next state IDLE, din=000, busy=0.
  - No done pulse; pass=0.
  - err_cnt and fail_vec freeze at their partial values.
  - abort in IDLE: no effect, and start is ignored that cycle.
- Simultaneous start and abort in IDLE: abort wins, remain IDLE.
- err_cnt maximum is 8; it cannot wrap.
- gate_dout is sampled only in SAMPLE and ignored elsewhere.

Test Plan:
1. Healthy NOR gate, SETTLE_CYC=1, start pulse at cycle t -> din steps 000..111, done high at t+17 only, pass=1, err_cnt=0, fail_vec=8'h00.
2. gate_dout stuck at 0 -> done at t+17, pass=0, err_cnt=4'd1, fail_vec=8'h01.
3. gate_dout stuck at 1 -> pass=0, err_cnt=4'd7, fail_vec=8'hFE. An OR gate substituted for the NOR -> err_cnt=4'd8, fail_vec=8'hFF.
4. abort while vec=3 is in DRIVE -> next cycle busy=0 and din=000; done is never pulsed; pass=0; fail_vec/err_cnt keep their partial values. A new start then gives a full clean run with pass=1.
5. rst_n low mid-run, start pulsed while busy, and start+abort together in IDLE:
   - rst_n low -> all outputs 0 on the next edge.
   - start while busy -> ignored, run timing unchanged.
   - start+abort in IDLE -> remains IDLE.
6. SETTLE_CYC=3, healthy gate -> each vector held 3 cycles before sampling, done at t+33, pass=1.
